decodificador_display: RTL and testbench
========================================

Name: decodificador_display

Overview:
- Reverse direction of the hex-to-7-segment encoder. Monitors a multiplexed 7-segment display bus and reconstructs the hex value shown on each digit.
- Inputs are the segment lines and digit enables. The block debounces them, decodes each stable pattern back to a nibble and flags patterns that are not legal glyphs.
- Used as a self-check monitor beside the display driver and as a scoreboard source in board-level benches.

Parameters:
- N_DIG, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical cycles required before a commit (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  8  segment lines. Bit7=a, 6=b, 5=c, 4=d, 3=e, 2=f, 1=g, 0=dp. Active-high.
- an_in  in  N_DIG  digit enables, active-high, one-hot when valid.
- hex_out  out  4*N_DIG  decoded nibble per digit. Digit d occupies [4d+3:4d].
- dp_out  out  N_DIG  decimal-point state per digit.
- valid  out  N_DIG  digit holds a decoded legal glyph.
- err  out  N_DIG  last committed pattern for the digit was illegal.
- upd  out  1  one-cycle pulse on every commit.
- upd_idx  out  max(1,clog2(N_DIG))  index of the digit committed with upd.
- frame_done  out  1  one-cycle pulse when every digit has committed since the previous pulse.

Behaviour:
- Reset (async, rst=1): all outputs 0; sample registers, run counter and seen-mask cleared. Release takes effect on the next clk edge. Reset mid-run discards the partial run; no commit is produced.
- Sampling: {an_in, seg_in} is registered every edge. The run counter increments, saturating at STABLE_CYCLES, while the new sample equals the previous one. The counter resets to 1 on any difference.
- Commit: occurs when the counter reaches exactly STABLE_CYCLES and an_in is one-hot.
  - Latency: inputs first present at edge k and held constant commit at edge k+STABLE_CYCLES-1. Outputs are visible after that edge.
  - Exactly one commit per constant run. Saturation prevents repeats.
- Zero or multi-hot an_in: never commits. The run is still counted, so a later change restarts it.
- Decode uses seg_in[7:1]; dp is taken from seg_in[0]. Legal table of seg[7:1] pattern -> nibble:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3
  - 0110011->4, 1011011->5, 1011111->6, 1110000->7
  - 1111111->8, 1111011->9, 1110111->A, 0011111->B
  - 1001110->C, 0111101->D, 1001111->E, 1000111->F
- On commit to digit d:
  - Legal glyph: hex[d]=nibble, valid[d]=1, err[d]=0, dp_out[d]=seg_in[0].
  - Blank (seg[7:1]=0): valid[d]=0, err[d]=0, hex[d] retained, dp_out[d] updated.
  - Any other pattern: valid[d]=0, err[d]=1, hex[d] retained, dp_out[d] updated.
- upd=1 and upd_idx=d for the cycle after the commit edge. upd_idx holds its value when upd=0.
- Seen-mask: bit d is set on each commit.
  - When the mask with the new bit becomes all-ones, frame_done pulses in the same cycle as upd and the mask clears to 0.
  - Repeated commits to an already-seen digit do not pulse.

Test Plan:
- Reset: rst=1 mid-stream -> all outputs 0 immediately. After release, no upd until STABLE_CYCLES identical samples.
- Legal decode: an_in=0001, seg_in=0xDA held 4 cycles -> hex_out[3:0]=2, valid[0]=1, err[0]=0, dp_out[0]=0, upd pulse with upd_idx=0 on cycle 4. Holding 10 more cycles produces no further upd.
- Glitch rejection: seg_in toggles 0x60/0xF2 every 2 cycles on digit 1 -> no upd. Hold 0xF2 for 4 cycles -> hex digit1=3.
- Illegal and blank: digit 2 with 0x02 (g only) -> err[2]=1, valid[2]=0, hex retained. Then 0x01 (dp only) -> err[2]=0, valid[2]=0, dp_out[2]=1.
- Bus faults: an_in=0011 or 0000 held 20 cycles -> no upd, all outputs unchanged.
- Frame: scan digits 0..3 with 0xFC,0x60,0xDA,0xF2, 4 cycles each -> hex_out=16'h3210, frame_done pulses together with the digit-3 upd. Rescanning digit 0 alone gives no frame_done.

Source files
------------

// File: rtl/decodificador_display_if.sv
// Bundle of the monitored display bus (segments + digit enables) and the decoded results.
// The master side drives the display lines; the slave side is the decoder.
interface decodificador_display_if #(
    parameter int N_DIG = 4
);
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [7:0]         seg_in;
    logic [N_DIG-1:0]   an_in;
    logic [4*N_DIG-1:0] hex_out;
    logic [N_DIG-1:0]   dp_out;
    logic [N_DIG-1:0]   valid;
    logic [N_DIG-1:0]   err;
    logic               upd;
    logic [IW-1:0]      upd_idx;
    logic               frame_done;

    modport master (
        output seg_in, an_in,
        input  hex_out, dp_out, valid, err, upd, upd_idx, frame_done
    );

    modport slave (
        input  seg_in, an_in,
        output hex_out, dp_out, valid, err, upd, upd_idx, frame_done
    );
endinterface

// File: rtl/decodificador_display.sv
// Monitors a multiplexed 7-segment bus, debounces each scan step and decodes the
// stable glyph back into a per-digit nibble, decimal point and legality flags.
module decodificador_display #(
    parameter int N_DIG         = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic                    clk,
    input logic                    rst,
    decodificador_display_if.slave bus
);
    localparam int         IW     = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int         SW     = N_DIG + 8;
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [SW-1:0]      samp_q, samp_d;
    logic [7:0]         run_q, run_d;
    logic [4*N_DIG-1:0] hex_q, hex_d;
    logic [N_DIG-1:0]   dp_q, dp_d;
    logic [N_DIG-1:0]   valid_q, valid_d;
    logic [N_DIG-1:0]   err_q, err_d;
    logic [N_DIG-1:0]   seen_q, seen_d;
    logic [N_DIG-1:0]   seen_nxt;
    logic               upd_q, upd_d;
    logic [IW-1:0]      upd_idx_q, upd_idx_d;
    logic               frame_q, frame_d;
    logic               commit;
    logic [IW-1:0]      dig_idx;
    logic [4:0]         glyph;

    // Returns {legal, nibble}; blank and unknown patterns both report not-legal.
    function automatic logic [4:0] decode_glyph(input logic [6:0] p);
        case (p)
            7'b1111110: decode_glyph = 5'h10;
            7'b0110000: decode_glyph = 5'h11;
            7'b1101101: decode_glyph = 5'h12;
            7'b1111001: decode_glyph = 5'h13;
            7'b0110011: decode_glyph = 5'h14;
            7'b1011011: decode_glyph = 5'h15;
            7'b1011111: decode_glyph = 5'h16;
            7'b1110000: decode_glyph = 5'h17;
            7'b1111111: decode_glyph = 5'h18;
            7'b1111011: decode_glyph = 5'h19;
            7'b1110111: decode_glyph = 5'h1A;
            7'b0011111: decode_glyph = 5'h1B;
            7'b1001110: decode_glyph = 5'h1C;
            7'b0111101: decode_glyph = 5'h1D;
            7'b1001111: decode_glyph = 5'h1E;
            7'b1000111: decode_glyph = 5'h1F;
            default:    decode_glyph = 5'h00;
        endcase
    endfunction

    always_comb begin
        samp_d    = {bus.an_in, bus.seg_in};
        hex_d     = hex_q;
        dp_d      = dp_q;
        valid_d   = valid_q;
        err_d     = err_q;
        seen_d    = seen_q;
        seen_nxt  = seen_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        frame_d   = 1'b0;
        dig_idx   = '0;
        glyph     = decode_glyph(bus.seg_in[7:1]);

        // Saturation at STABLE makes the commit a single event per constant run.
        if (samp_d != samp_q) begin
            run_d = 8'd1;
        end else if (run_q == STABLE) begin
            run_d = run_q;
        end else begin
            run_d = run_q + 8'd1;
        end
        commit = (samp_d == samp_q) && (run_q == STABLE - 8'd1) && $onehot(bus.an_in);

        for (int i = 0; i < N_DIG; i++) begin
            if (bus.an_in[i]) dig_idx = IW'(i);
        end

        if (commit) begin
            dp_d[dig_idx] = bus.seg_in[0];
            if (glyph[4]) begin
                hex_d[dig_idx*4 +: 4] = glyph[3:0];
                valid_d[dig_idx]      = 1'b1;
                err_d[dig_idx]        = 1'b0;
            end else begin
                valid_d[dig_idx] = 1'b0;
                err_d[dig_idx]   = |bus.seg_in[7:1];
            end
            upd_d     = 1'b1;
            upd_idx_d = dig_idx;
            seen_nxt  = seen_q | (N_DIG'(1) << dig_idx);
            if (&seen_nxt) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d = seen_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q    <= '0;
            run_q     <= '0;
            hex_q     <= '0;
            dp_q      <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            seen_q    <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            samp_q    <= samp_d;
            run_q     <= run_d;
            hex_q     <= hex_d;
            dp_q      <= dp_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            seen_q    <= seen_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.hex_out    = hex_q;
    assign bus.dp_out     = dp_q;
    assign bus.valid      = valid_q;
    assign bus.err        = err_q;
    assign bus.upd        = upd_q;
    assign bus.upd_idx    = upd_idx_q;
    assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_decodificador_display.sv
// Bench for decodificador_display: directed scenarios plus randomized scan traffic,
// checked every cycle against a run-length/table-lookup model of the decoder.
module tb_decodificador_display;
    localparam int N_DIG = 4;
    localparam int S     = 4;

    logic clk;
    logic rst;
    int   tests  = 0;
    int   failed = 0;
    int   upd_cnt = 0;
    int   frame_cnt = 0;

    decodificador_display_if #(.N_DIG(N_DIG)) bus();

    decodificador_display #(.N_DIG(N_DIG), .STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit [6:0] glyph_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic [11:0]        m_prev;
    int                 m_run;
    logic [N_DIG-1:0]   m_seen;
    logic [4*N_DIG-1:0] m_hex;
    logic [N_DIG-1:0]   m_dp, m_valid, m_err;
    logic               m_upd, m_frame;
    logic [1:0]         m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev = '0; m_run = 0; m_seen = '0; m_hex = '0;
            m_dp = '0; m_valid = '0; m_err = '0;
            m_upd = 1'b0; m_frame = 1'b0; m_idx = '0;
        end else begin
            logic [11:0] cur;
            int          d;
            int          nib;
            cur = {bus.an_in, bus.seg_in};
            m_run  = (cur == m_prev) ? m_run + 1 : 1;
            m_prev = cur;
            m_upd  = 1'b0;
            m_frame = 1'b0;
            if (m_run == S && $countones(bus.an_in) == 1) begin
                d = 0;
                for (int i = 0; i < N_DIG; i++) if (bus.an_in[i]) d = i;
                nib = -1;
                for (int i = 0; i < 16; i++) if (glyph_tab[i] == bus.seg_in[7:1]) nib = i;
                m_dp[d] = bus.seg_in[0];
                if (nib >= 0) begin
                    m_hex[d*4 +: 4] = 4'(nib);
                    m_valid[d] = 1'b1;
                    m_err[d]   = 1'b0;
                end else begin
                    m_valid[d] = 1'b0;
                    m_err[d]   = (bus.seg_in[7:1] != 7'd0);
                end
                m_upd = 1'b1;
                m_idx = 2'(d);
                m_seen[d] = 1'b1;
                if (m_seen == {N_DIG{1'b1}}) begin
                    m_frame = 1'b1;
                    m_seen  = '0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check("hex_out",    32'(bus.hex_out),    32'(m_hex));
        check("dp_out",     32'(bus.dp_out),     32'(m_dp));
        check("valid",      32'(bus.valid),      32'(m_valid));
        check("err",        32'(bus.err),        32'(m_err));
        check("upd",        32'(bus.upd),        32'(m_upd));
        check("upd_idx",    32'(bus.upd_idx),    32'(m_idx));
        check("frame_done", 32'(bus.frame_done), 32'(m_frame));
        upd_cnt   += int'(bus.upd);
        frame_cnt += int'(bus.frame_done);
    end

    // ---------------- driver ----------------
    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        @(negedge clk);
        bus.an_in  = an;
        bus.seg_in = seg;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hex"},   32'(bus.hex_out), 32'h0);
        check({tag, "_valid"}, 32'(bus.valid),   32'h0);
        check({tag, "_err"},   32'(bus.err),     32'h0);
        check({tag, "_dp"},    32'(bus.dp_out),  32'h0);
        check({tag, "_upd"},   32'(bus.upd),     32'h0);
    endtask

    initial begin
        #1_000_000;
        failed++;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int u0;
        int f0;
        bus.an_in  = '0;
        bus.seg_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Legal decode and single commit per run
        hold(4'b0001, 8'hDA, S);
        check("legal_upd",   32'(bus.upd),          32'h1);
        check("legal_idx",   32'(bus.upd_idx),      32'h0);
        check("legal_hex0",  32'(bus.hex_out[3:0]), 32'h2);
        check("legal_valid", 32'(bus.valid[0]),     32'h1);
        check("legal_err",   32'(bus.err[0]),       32'h0);
        check("legal_dp",    32'(bus.dp_out[0]),    32'h0);
        u0 = upd_cnt;
        hold(4'b0001, 8'hDA, 10);
        check("hold_no_repeat", 32'(upd_cnt - u0), 32'h0);

        // Glitch rejection on digit 1
        u0 = upd_cnt;
        for (int i = 0; i < 5; i++) hold(4'b0010, (i % 2 == 0) ? 8'h60 : 8'hF2, 2);
        check("glitch_no_upd", 32'(upd_cnt - u0), 32'h0);
        hold(4'b0010, 8'hF2, S);
        check("glitch_hex1", 32'(bus.hex_out[7:4]), 32'h3);
        check("glitch_upd",  32'(bus.upd),          32'h1);

        // Illegal then blank with dp on digit 2
        hold(4'b0100, 8'h02, S);
        check("illegal_err",   32'(bus.err[2]),        32'h1);
        check("illegal_valid", 32'(bus.valid[2]),      32'h0);
        check("illegal_hex2",  32'(bus.hex_out[11:8]), 32'h0);
        hold(4'b0100, 8'h01, S);
        check("blank_err",   32'(bus.err[2]),    32'h0);
        check("blank_valid", 32'(bus.valid[2]),  32'h0);
        check("blank_dp",    32'(bus.dp_out[2]), 32'h1);

        // Bus faults never commit
        u0 = upd_cnt;
        hold(4'b0011, 8'hFC, 20);
        hold(4'b0000, 8'hFC, 20);
        check("busfault_no_upd", 32'(upd_cnt - u0), 32'h0);
        check("busfault_hex",    32'(bus.hex_out),  32'h0032);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        bus.an_in = 4'b0001; bus.seg_in = 8'hFC;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        u0 = upd_cnt;
        repeat (S - 1) @(posedge clk);
        #2 check("post_rst_quiet", 32'(upd_cnt - u0), 32'h0);
        @(posedge clk);
        #2 check("post_rst_upd", 32'(bus.upd), 32'h1);

        // Frame scan
        hold(4'b0010, 8'h60, S);
        hold(4'b0100, 8'hDA, S);
        f0 = frame_cnt;
        hold(4'b1000, 8'hF2, S);
        check("frame_pulse", 32'(bus.frame_done), 32'h1);
        check("frame_idx",   32'(bus.upd_idx),    32'h3);
        check("frame_hex",   32'(bus.hex_out),    32'h3210);
        hold(4'b0001, 8'hFC, S);
        check("rescan_no_frame", 32'(frame_cnt - f0), 32'h1);
        check("rescan_upd",      32'(bus.upd),        32'h1);

        // Randomized scan traffic
        for (int it = 0; it < 400; it++) begin
            logic [3:0] an;
            logic [7:0] seg;
            int r;
            r = $urandom_range(0, 11);
            if (r < 8)       an = 4'(1 << (r % 4));
            else if (r == 8) an = 4'b0000;
            else if (r == 9) an = 4'b0101;
            else             an = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) seg = {glyph_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
            else                          seg = 8'($urandom_range(0, 255));
            hold(an, seg, $urandom_range(1, 7));
            if (it == 200) begin
                #1 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
